// File: rtl/piece_action_sched_if.sv
// Bundle of game-FSM handshake signals between the game controller and the
// piece action scheduler. The master side drives key/game inputs; the slave
// side (the scheduler) returns the requested next state and status flags.
interface piece_action_sched_if #(
    parameter int STATE_W = 3
);
    logic [STATE_W-1:0] game_current_state;
    logic               rotate;
    logic               move_left;
    logic               move_right;
    logic               move_tobottom;
    logic               en_fall;
    logic               will_collide_below;
    logic               new_piece;
    logic [STATE_W-1:0] game_next_state_generate;
    logic               move_dir;
    logic               action_valid;
    logic               lock_pending;

    modport master (
        output game_current_state, rotate, move_left, move_right, move_tobottom,
               en_fall, will_collide_below, new_piece,
        input  game_next_state_generate, move_dir, action_valid, lock_pending
    );

    modport slave (
        input  game_current_state, rotate, move_left, move_right, move_tobottom,
               en_fall, will_collide_below, new_piece,
        output game_next_state_generate, move_dir, action_valid, lock_pending
    );
endinterface

// File: rtl/piece_action_sched.sv
// Piece action scheduler: turns player key levels, gravity ticks and the
// grounded flag into one requested game state per cycle, with rotate and
// hard-drop edge detection and DAS/ARR auto-repeat for left/right moves.
// Optional feature macro: LOCK_DELAY_EN enables a lock-delay timer with a
// bounded number of restarts per piece; without it a grounded gravity tick
// requests COLLISION immediately.
// State codes follow the tetris_states.vh encoding; they are defined here
// only when that header has not already been pulled in.
`ifndef GENERATE_PIECE
`define GENERATE_PIECE 3'd0
`define ROTATE_PIECE   3'd1
`define MOVE           3'd2
`define TOBOTTOM       3'd3
`define COLLISION      3'd4
`endif

module piece_action_sched #(
    parameter int STATE_W     = 3,
    parameter int CNT_W       = 8,
    parameter int DAS_CYCLES  = 16,
    parameter int ARR_CYCLES  = 4,
    parameter int LOCK_CYCLES = 30,
    parameter int LOCK_RESETS = 8
) (
    input logic                clk,
    input logic                rst_n,
    piece_action_sched_if.slave bus
);

    localparam logic [STATE_W-1:0] ST_GEN  = STATE_W'(`GENERATE_PIECE);
    localparam logic [STATE_W-1:0] ST_ROT  = STATE_W'(`ROTATE_PIECE);
    localparam logic [STATE_W-1:0] ST_MOVE = STATE_W'(`MOVE);
    localparam logic [STATE_W-1:0] ST_TOB  = STATE_W'(`TOBOTTOM);
    localparam logic [STATE_W-1:0] ST_COLL = STATE_W'(`COLLISION);

    localparam logic [CNT_W-1:0] DAS_L = CNT_W'(DAS_CYCLES);
    localparam logic [CNT_W-1:0] ARR_L = CNT_W'(ARR_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Edge-detect history for rotate / hard drop
    logic rotate_q, tobottom_q;
    // Auto-repeat tracking: hold counter, ARR phase flag, direction being held
    logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
    logic             hold_arr, hold_arr_d;
    logic             hold_dir;
    // Registered outputs
    logic [STATE_W-1:0] next_q, next_d;
    logic               valid_q, valid_d;
    logic               dir_q, dir_d;
    logic               pend_q, pend_d;

    logic rotate_edge, tobottom_edge, one_side, key_dir, in_gen, move_evt, expire;

    assign rotate_edge   = bus.rotate & ~rotate_q;
    assign tobottom_edge = bus.move_tobottom & ~tobottom_q;
    assign one_side      = bus.move_left ^ bus.move_right;
    assign key_dir       = bus.move_right;
    assign in_gen        = (bus.game_current_state == ST_GEN);

`ifdef LOCK_DELAY_EN
    localparam logic [CNT_W-1:0] LOCK_LAST_L = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_RST_L  = CNT_W'(LOCK_RESETS);

    logic [CNT_W-1:0] lock_cnt, lock_cnt_d;
    logic [CNT_W-1:0] lock_rst_cnt, lock_rst_cnt_d;
    logic             unused_en_fall;

    // Gravity ticks do not drive locking once the lock timer owns it
    assign unused_en_fall = bus.en_fall;
    // New piece suppresses an expiry landing in the same cycle
    assign expire = in_gen && bus.will_collide_below && !bus.new_piece &&
                    (lock_cnt >= LOCK_LAST_L);
`else
    localparam int unused_lock_cfg = LOCK_CYCLES + LOCK_RESETS;
    logic unused_new_piece;

    assign unused_new_piece = bus.new_piece;
    assign expire           = in_gen && bus.en_fall && bus.will_collide_below;
`endif

    // Move event generation: immediate on press, then DAS delay, then ARR period
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        move_evt   = 1'b0;
        hold_cnt_d = hold_cnt;
        hold_arr_d = hold_arr;
        if (!one_side) begin
            hold_cnt_d = '0;
            hold_arr_d = 1'b0;
        end else if (hold_cnt == '0 || key_dir != hold_dir) begin
            move_evt   = 1'b1;
            hold_cnt_d = CNT_W'(1);
            hold_arr_d = 1'b0;
        end else if (!hold_arr) begin
            if (hold_cnt >= DAS_L) begin
                move_evt   = 1'b1;
                hold_cnt_d = CNT_W'(1);
                hold_arr_d = 1'b1;
            end else begin
                hold_cnt_d = sat_inc(hold_cnt);
            end
        end else begin
            if (hold_cnt >= ARR_L) begin
                move_evt   = 1'b1;
                hold_cnt_d = CNT_W'(1);
            end else begin
                hold_cnt_d = sat_inc(hold_cnt);
            end
        end
    end

    // Arbitration of the single requested action plus lock-timer bookkeeping
    always_comb begin
        next_d = ST_GEN;
        dir_d  = dir_q;
        pend_d = 1'b0;
`ifdef LOCK_DELAY_EN
        pend_d         = pend_q;
        lock_cnt_d     = lock_cnt;
        lock_rst_cnt_d = lock_rst_cnt;
`endif
        if (in_gen) begin
            if (expire) begin
                next_d = ST_COLL;
            end else if (rotate_edge) begin
                next_d = ST_ROT;
            end else if (move_evt) begin
                next_d = ST_MOVE;
                dir_d  = key_dir;
            end else if (tobottom_edge) begin
                next_d = ST_TOB;
            end
        end
        valid_d = (next_d != ST_GEN);
`ifdef LOCK_DELAY_EN
        if (bus.new_piece) begin
            lock_cnt_d     = '0;
            lock_rst_cnt_d = '0;
            pend_d         = 1'b0;
        end else if (in_gen) begin
            if (!bus.will_collide_below || expire) begin
                lock_cnt_d = '0;
                pend_d     = 1'b0;
            end else begin
                pend_d = 1'b1;
                if ((next_d == ST_ROT || next_d == ST_MOVE) && lock_rst_cnt < LOCK_RST_L) begin
                    lock_cnt_d     = '0;
                    lock_rst_cnt_d = lock_rst_cnt + CNT_W'(1);
                end else begin
                    lock_cnt_d = sat_inc(lock_cnt);
                end
            end
        end
`endif
    end

    // State and output registers; reset aborts any hold or lock in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rotate_q   <= 1'b0;
            tobottom_q <= 1'b0;
            hold_cnt   <= '0;
            hold_arr   <= 1'b0;
            hold_dir   <= 1'b0;
            next_q     <= ST_GEN;
            valid_q    <= 1'b0;
            dir_q      <= 1'b0;
            pend_q     <= 1'b0;
`ifdef LOCK_DELAY_EN
            lock_cnt     <= '0;
            lock_rst_cnt <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rotate_q   <= bus.rotate;
            tobottom_q <= bus.move_tobottom;
            hold_cnt   <= hold_cnt_d;
            hold_arr   <= hold_arr_d;
            hold_dir   <= one_side ? key_dir : hold_dir;
            next_q     <= next_d;
            valid_q    <= valid_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
`ifdef LOCK_DELAY_EN
            lock_cnt     <= lock_cnt_d;
            lock_rst_cnt <= lock_rst_cnt_d;
`endif
        end
    end

    assign bus.game_next_state_generate = next_q;
    assign bus.action_valid             = valid_q;
    assign bus.move_dir                 = dir_q;
    assign bus.lock_pending             = pend_q;

endmodule

// File: tb/tb_piece_action_sched.sv
// Directed bench for piece_action_sched: reset values, DAS/ARR timing,
// rotate/drop edge detection, arbitration, non-GENERATE_PIECE behaviour,
// collision/lock behaviour (either build) and asynchronous reset mid-hold.
module tb_piece_action_sched;

    localparam logic [2:0] S_GEN  = 3'd0;
    localparam logic [2:0] S_ROT  = 3'd1;
    localparam logic [2:0] S_MOVE = 3'd2;
    localparam logic [2:0] S_TOB  = 3'd3;
    localparam logic [2:0] S_COLL = 3'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    piece_action_sched_if #(.STATE_W(3)) bus ();

    piece_action_sched #(
        .STATE_W(3), .CNT_W(8), .DAS_CYCLES(16), .ARR_CYCLES(4),
        .LOCK_CYCLES(30), .LOCK_RESETS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st, input logic av);
        check({tag, "_state"}, bus.game_next_state_generate, st);
        check({tag, "_valid"}, bus.action_valid, av);
    endtask

    initial begin
        int rot_cnt;
        int pulse_cnt;
        bus.game_current_state = S_GEN;
        bus.rotate             = 1'b0;
        bus.move_left          = 1'b0;
        bus.move_right         = 1'b0;
        bus.move_tobottom      = 1'b0;
        bus.en_fall            = 1'b0;
        bus.will_collide_below = 1'b0;
        bus.new_piece          = 1'b0;

        // Reset values, visible before any clock edge
        #2;
        expect_out("reset", S_GEN, 1'b0);
        check("reset_dir", bus.move_dir, 1'b0);
        check("reset_pend", bus.lock_pending, 1'b0);
        #20 rst_n = 1'b1;
        step();
        expect_out("idle", S_GEN, 1'b0);

        // Hold right 40 cycles: moves at 1, 17, 21, 25, 29, 33, 37
        bus.move_right = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 1 || (n >= 17 && (n - 17) % 4 == 0)) begin
                expect_out($sformatf("das_r%0d", n), S_MOVE, 1'b1);
                check($sformatf("das_r%0d_dir", n), bus.move_dir, 1'b1);
            end else begin
                expect_out($sformatf("das_r%0d", n), S_GEN, 1'b0);
            end
        end
        bus.move_right = 1'b0;
        step();
        expect_out("das_release", S_GEN, 1'b0);

        // Hold rotate 10 cycles: exactly one rotate request and one pulse
        bus.rotate = 1'b1;
        rot_cnt    = 0;
        pulse_cnt  = 0;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (bus.game_next_state_generate == S_ROT) rot_cnt++;
            if (bus.action_valid) pulse_cnt++;
        end
        check("rot_hold_count", rot_cnt, 1);
        check("rot_hold_pulses", pulse_cnt, 1);
        bus.rotate = 1'b0;
        step();

        // Rotate edge and left press together: rotate wins, next move at 17
        bus.rotate    = 1'b1;
        bus.move_left = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            step();
            if (n == 1) expect_out("rotleft1", S_ROT, 1'b1);
            else if (n == 17) begin
                expect_out("rotleft17", S_MOVE, 1'b1);
                check("rotleft17_dir", bus.move_dir, 1'b0);
            end else if (n == 2 || n == 16) expect_out($sformatf("rotleft%0d", n), S_GEN, 1'b0);
        end
        bus.rotate    = 1'b0;
        bus.move_left = 1'b0;
        step();

        // Hard drop edge fires once while held
        bus.move_tobottom = 1'b1;
        step();
        expect_out("tob_edge", S_TOB, 1'b1);
        step();
        expect_out("tob_held", S_GEN, 1'b0);
        bus.move_tobottom = 1'b0;
        step();

        // Both keys: no move, counter cleared, direction kept
        bus.move_right = 1'b1;
        step();
        expect_out("both_pre", S_MOVE, 1'b1);
        bus.move_left = 1'b1;
        step();
        expect_out("both1", S_GEN, 1'b0);
        step();
        expect_out("both2", S_GEN, 1'b0);
        check("both_dir", bus.move_dir, 1'b1);
        bus.move_left = 1'b0;
        step();
        expect_out("both_after", S_MOVE, 1'b1);
        check("both_after_dir", bus.move_dir, 1'b1);
        bus.move_right = 1'b0;
        step();

        // Outside GENERATE_PIECE: move discarded but hold keeps counting
        bus.game_current_state = S_ROT;
        bus.move_left          = 1'b1;
        step();
        expect_out("ngen_move", S_GEN, 1'b0);
        bus.game_current_state = S_GEN;
        for (int n = 2; n <= 17; n++) begin
            step();
            if (n == 17) begin
                expect_out("ngen_das17", S_MOVE, 1'b1);
                check("ngen_das17_dir", bus.move_dir, 1'b0);
            end else if (n == 2) expect_out("ngen_das2", S_GEN, 1'b0);
        end
        bus.move_left = 1'b0;
        step();

        // Rotate edge consumed while not in GENERATE_PIECE
        bus.game_current_state = S_MOVE;
        bus.rotate             = 1'b1;
        step();
        expect_out("ngen_rot", S_GEN, 1'b0);
        bus.game_current_state = S_GEN;
        step();
        expect_out("ngen_rot_held", S_GEN, 1'b0);
        bus.rotate = 1'b0;
        step();

`ifndef LOCK_DELAY_EN
        // Grounded gravity tick: COLLISION next cycle, beats a rotate edge
        bus.will_collide_below = 1'b1;
        bus.en_fall            = 1'b1;
        bus.rotate             = 1'b1;
        step();
        expect_out("coll", S_COLL, 1'b1);
        check("coll_pend", bus.lock_pending, 1'b0);
        bus.en_fall = 1'b0;
        bus.rotate  = 1'b0;
        step();
        expect_out("coll_after", S_GEN, 1'b0);
        bus.will_collide_below = 1'b0;
        bus.en_fall            = 1'b1;
        step();
        expect_out("fall_air", S_GEN, 1'b0);
        bus.game_current_state = S_MOVE;
        bus.will_collide_below = 1'b1;
        step();
        expect_out("coll_ngen", S_GEN, 1'b0);
        bus.game_current_state = S_GEN;
        bus.will_collide_below = 1'b0;
        bus.en_fall            = 1'b0;
        step();
`else
        // Grounded with no keys: COLLISION 30 cycles after grounding
        bus.new_piece = 1'b1;
        step();
        bus.new_piece          = 1'b0;
        bus.will_collide_below = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (n == 1) check("lock_pend1", bus.lock_pending, 1'b1);
            if (n == 30) expect_out("lock30", S_COLL, 1'b1);
            else if (n == 29) expect_out("lock29", S_GEN, 1'b0);
        end
        bus.will_collide_below = 1'b0;
        step();
        check("lock_air_pend", bus.lock_pending, 1'b0);

        // LOCK_RESETS=2: rotates at 5, 15, 25; only two restart -> COLLISION at 45
        bus.new_piece = 1'b1;
        step();
        bus.new_piece          = 1'b0;
        bus.will_collide_below = 1'b1;
        for (int n = 1; n <= 46; n++) begin
            bus.rotate = (n == 5 || n == 15 || n == 25);
            step();
            if (n == 5 || n == 15 || n == 25) expect_out($sformatf("lrst%0d", n), S_ROT, 1'b1);
            else if (n == 45) expect_out("lrst45", S_COLL, 1'b1);
            else if (n == 44 || n == 35) expect_out($sformatf("lrst%0d", n), S_GEN, 1'b0);
        end
        bus.rotate             = 1'b0;
        bus.will_collide_below = 1'b0;
        step();
`endif

        // Reset mid-DAS with left held: immediate clear, new press after release
        bus.move_left = 1'b1;
        step();
        expect_out("rst_pre", S_MOVE, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        expect_out("rst_async", S_GEN, 1'b0);
        check("rst_async_pend", bus.lock_pending, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        expect_out("rst_newpress", S_MOVE, 1'b1);
        check("rst_newpress_dir", bus.move_dir, 1'b0);
        step();
        expect_out("rst_hold2", S_GEN, 1'b0);
        bus.move_left = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/piece_action_sched.md
PIECE_ACTION_SCHED -- requirements
Module: piece_action_sched

Interface
REQ-001 Parameter STATE_W, default 3: width of game state codes; state codes are the `GENERATE_PIECE`, `ROTATE_PIECE`, `MOVE`, `TOBOTTOM` and `COLLISION` macros from tetris_states.vh.
REQ-002 Parameter CNT_W, default 8: width of all internal counters.
REQ-003 Parameter DAS_CYCLES, default 16: hold cycles before left/right auto-repeat starts (1..2^CNT_W-1).
REQ-004 Parameter ARR_CYCLES, default 4: cycles between auto-repeat moves (1..2^CNT_W-1).
REQ-005 Parameter LOCK_CYCLES, default 30: grounded cycles before lock (1..2^CNT_W-1).
REQ-006 Parameter LOCK_RESETS, default 8: maximum lock-timer restarts per piece.
REQ-007 clk  in  1  system clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 game_current_state  in  STATE_W  current game FSM state.
REQ-010 rotate, move_left, move_right, move_tobottom  in  1 each  level-sensitive key inputs, already synchronised.
REQ-011 en_fall  in  1  single-cycle gravity tick.
REQ-012 will_collide_below  in  1  piece is grounded.
REQ-013 new_piece  in  1  single-cycle pulse when a new piece spawns.
REQ-014 game_next_state_generate  out  STATE_W  registered requested next state.
REQ-015 move_dir  out  1  registered; 0 = left, 1 = right; valid when game_next_state_generate == `MOVE`.
REQ-016 action_valid  out  1  registered one-cycle pulse when any non-`GENERATE_PIECE` state is requested.
REQ-017 lock_pending  out  1  registered; lock timer running.

Function
REQ-018 Arbitration in `GENERATE_PIECE` only, one action per cycle, priority: lock expiry > rotate edge > move event > tobottom edge > none.
REQ-019 rotate and move_tobottom act on rising edge only; edge registers update every cycle in every state.
REQ-020 Move event: first cycle of an exclusive left or right press fires immediately; after DAS_CYCLES further held cycles fires again, then every ARR_CYCLES while held.
REQ-021 left and right both high: no move event; DAS/ARR counter cleared; move_dir unchanged.
REQ-022 DAS/ARR counter tracks holding in all game states, but move events are discarded outside `GENERATE_PIECE`; counters saturate, never wrap.
REQ-023 No action: game_next_state_generate holds `GENERATE_PIECE`, action_valid 0.
REQ-024 game_current_state not `GENERATE_PIECE`: next cycle output `GENERATE_PIECE`, action_valid 0; lock counter and reset count hold.
REQ-025 en_fall with will_collide_below low: output `GENERATE_PIECE`, lock counter cleared, lock_pending 0.
REQ-026 new_piece clears lock counter, lock_pending and lock-reset count; dominates same-cycle lock expiry.
REQ-027 Latency: every decision appears exactly one clock after the sampled inputs.

Reset
REQ-028 On rst_n low, immediately: game_next_state_generate = `GENERATE_PIECE`, move_dir = 0, action_valid = 0, lock_pending = 0, all counters and edge registers 0.
REQ-029 Reset asserted mid-hold or mid-lock aborts the operation; after release a still-held key counts as a new press on the first clock.

Configuration
REQ-030 Macro LOCK_DELAY_EN defined: in `GENERATE_PIECE` with will_collide_below high, lock_pending = 1 and lock counter increments per cycle; at LOCK_CYCLES output `COLLISION`, clear counter.
REQ-031 With LOCK_DELAY_EN: an issued rotate or move while grounded restarts the lock counter if reset count < LOCK_RESETS, incrementing reset count; otherwise no restart.
REQ-032 With LOCK_DELAY_EN: will_collide_below low clears the lock counter (not reset count).
REQ-033 Without LOCK_DELAY_EN: en_fall with will_collide_below high outputs `COLLISION` next cycle, top priority; lock_pending tied 0; lock counters absent.

Verification
REQ-034 Hold move_right 40 cycles from `GENERATE_PIECE`, DAS=16, ARR=4 -> `MOVE` with move_dir=1 at cycles 1, 17, 21, 25, 29, 33, 37.
REQ-035 Hold rotate 10 cycles -> exactly one `ROTATE_PIECE`, action_valid one pulse.
REQ-036 rotate rising edge and move_left press same cycle -> `ROTATE_PIECE`; move event lost, next move at cycle 17 if held.
REQ-037 LOCK_DELAY_EN, LOCK_CYCLES=30, grounded, no keys -> `COLLISION` 30 cycles after grounding; without macro, en_fall while grounded -> `COLLISION` next cycle.
REQ-038 LOCK_DELAY_EN, LOCK_RESETS=2, grounded, three rotates spaced 10 cycles -> only first two restart timer; `COLLISION` 30 cycles after second.
REQ-039 rst_n pulsed low mid-DAS with move_left held -> outputs clear asynchronously; `MOVE` left on first clock after release.
